// File: rtl/ham32_encoder.sv
`default_nettype none
// ============================================================================
// Module   : ham32_encoder
// Brief    : Two-stage pipelined 26->32 extended Hamming (SEC-DED) encoder
//            with a valid/ready stream on both sides and a delivered-word
//            counter. Build option HAM32_ERR_INJECT_EN adds err_inj_mask,
//            which is XORed into the emitted codeword.
// Revision : 1.0 - initial release
// ============================================================================
module ham32_encoder (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [25:0] in_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_codeword,
   output logic [15:0] enc_count
`ifdef HAM32_ERR_INJECT_EN
   ,
   input  logic [31:0] err_inj_mask
`endif
);

   // Data-bit participation masks for parity bits cw[31]..cw[27]
   localparam logic [25:0] c_P31_MASK = 26'h36AD555;
   localparam logic [25:0] c_P30_MASK = 26'h2D9B333;
   localparam logic [25:0] c_P29_MASK = 26'h1C78F0F;
   localparam logic [25:0] c_P28_MASK = 26'h03F80FF;
   localparam logic [25:0] c_P27_MASK = 26'h0007FFF;

   // Stage 1: data word plus the five Hamming parity bits
   logic        r_s1_valid;
   logic [25:0] r_s1_data;
   logic [4:0]  r_s1_par;

   // Stage 2: complete codeword
   logic        r_s2_valid;
   logic [31:0] r_s2_cw;

   logic [15:0] r_enc_count;

   logic        w_s2_adv;
   logic        w_s1_adv;
   logic        w_accept;
   logic        w_deliver;
   logic [4:0]  w_par;
   logic        w_overall;

   // Flow control: a stage may take new contents when empty or when its
   // downstream neighbour is moving; this lets a full pipe accept and
   // deliver in the same cycle without a bubble.
   assign w_s2_adv  = !r_s2_valid | out_ready;
   assign w_s1_adv  = !r_s1_valid | w_s2_adv;
   assign in_ready  = w_s1_adv;
   assign w_accept  = in_valid & w_s1_adv;
   assign w_deliver = r_s2_valid & out_ready;

   // Hamming parity bits, ordered {cw[31], cw[30], cw[29], cw[28], cw[27]}
   assign w_par = {^(in_data & c_P31_MASK),
                   ^(in_data & c_P30_MASK),
                   ^(in_data & c_P29_MASK),
                   ^(in_data & c_P28_MASK),
                   ^(in_data & c_P27_MASK)};

   // Overall parity makes the 32-bit codeword even weight
   assign w_overall = ^{r_s1_par, r_s1_data};

   // Stage 1 register: data is captured only on an accepted handshake so
   // in_data is ignored while in_valid is low.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1_valid <= 1'b0;
         r_s1_data  <= '0;
         r_s1_par   <= '0;
      end else if (w_s1_adv) begin
         r_s1_valid <= in_valid;
         if (w_accept) begin
            r_s1_data <= in_data;
            r_s1_par  <= w_par;
         end
      end
   end

   // Stage 2 register: holds the finished codeword, frozen while stalled
   always_ff @(posedge clk) begin
      if (rst) begin
         r_s2_valid <= 1'b0;
         r_s2_cw    <= '0;
      end else if (w_s2_adv) begin
         r_s2_valid <= r_s1_valid;
         if (r_s1_valid) begin
            r_s2_cw <= {r_s1_par, w_overall, r_s1_data};
         end
      end
   end

   // Delivered-codeword counter, wraps naturally at 16 bits
   always_ff @(posedge clk) begin
      if (rst) begin
         r_enc_count <= '0;
      end else if (w_deliver) begin
         r_enc_count <= r_enc_count + 16'd1;
      end
   end

   assign out_valid = r_s2_valid;
   assign enc_count = r_enc_count;

`ifdef HAM32_ERR_INJECT_EN
   // Error injection is applied after the pipeline so the mask acts at once
   assign out_codeword = r_s2_cw ^ err_inj_mask;
`else
   assign out_codeword = r_s2_cw;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ham32_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_ham32_encoder
// Brief    : Self-checking bench for ham32_encoder: a parity-list reference
//            model with an in-flight word queue, a per-cycle compare process,
//            and directed scenarios with literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ham32_encoder;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [25:0] in_data = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_codeword;
   logic [15:0] enc_count;
   logic [31:0] err_inj_mask = '0;

   int checks = 0;
   int errors = 0;

   ham32_encoder dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_data      (in_data),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_codeword (out_codeword),
      .enc_count    (enc_count)
`ifdef HAM32_ERR_INJECT_EN
      ,
      .err_inj_mask (err_inj_mask)
`endif
   );

   always #5 clk = ~clk;

   // Parity participation lists straight from the code definition
   localparam int P31_IDX [15] = '{0,2,4,6,8,10,12,14,15,17,19,21,22,24,25};
   localparam int P30_IDX [15] = '{0,1,4,5,8,9,12,13,15,16,19,20,22,23,25};
   localparam int P29_IDX [15] = '{0,1,2,3,8,9,10,11,15,16,17,18,22,23,24};
   localparam int P28_IDX [15] = '{0,1,2,3,4,5,6,7,15,16,17,18,19,20,21};

   function automatic logic [31:0] model_enc(input logic [25:0] d);
      logic [31:0] cw;
      cw = '0;
      cw[25:0] = d;
      for (int i = 0; i < 15; i++) begin
         cw[31] = cw[31] ^ d[P31_IDX[i]];
         cw[30] = cw[30] ^ d[P30_IDX[i]];
         cw[29] = cw[29] ^ d[P29_IDX[i]];
         cw[28] = cw[28] ^ d[P28_IDX[i]];
         cw[27] = cw[27] ^ d[i];
      end
      cw[26] = ^{cw[31:27], cw[25:0]};
      return cw;
   endfunction

   // Decoder-style syndrome: {parity-check mismatches, overall parity}
   function automatic logic [5:0] syndrome(input logic [31:0] cw);
      logic [31:0] ref_cw;
      logic [5:0]  s;
      ref_cw = model_enc(cw[25:0]);
      s[5:1] = ref_cw[31:27] ^ cw[31:27];
      s[0]   = ^cw;
      return s;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference model state: words in flight with their accept cycle
   typedef struct {
      logic [31:0] cw;
      int          acc;
   } item_t;

   item_t       q[$];
   logic [15:0] m_count = '0;
   bit          live = 1'b0;
   int          cyc = 0;

   // Model update at each rising edge
   always begin
      @(posedge clk);
      if (rst) begin
         q.delete();
         m_count = '0;
         live    = 1'b1;
      end else if (live) begin
         bit    exp_ov;
         bit    exp_rdy;
         item_t it;
         exp_ov  = (q.size() > 0) && (q[0].acc + 2 <= cyc);
         exp_rdy = (q.size() < 2) || out_ready;
         if (exp_ov && out_ready) begin
            void'(q.pop_front());
            m_count = m_count + 16'd1;
         end
         if (in_valid && exp_rdy) begin
            it.cw  = model_enc(in_data);
            it.acc = cyc;
            q.push_back(it);
         end
      end
      cyc++;
   end

   // Per-cycle comparison of DUT outputs against the model
   always begin
      @(negedge clk);
      if (live) begin
         bit exp_ov;
         bit exp_rdy;
         exp_ov  = (q.size() > 0) && (q[0].acc + 2 <= cyc);
         exp_rdy = (q.size() < 2) || out_ready;
         chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
         chk("out_valid", {31'd0, out_valid}, {31'd0, exp_ov});
         chk("enc_count", {16'd0, enc_count}, {16'd0, m_count});
         if (exp_ov) begin
            chk("codeword", out_codeword, q[0].cw ^ err_inj_mask);
            if (err_inj_mask == 32'd0) begin
               chk("syndrome", {26'd0, syndrome(out_codeword)}, 32'd0);
            end
         end
      end
   end

   // Present one word and hold it until the encoder accepts it
   task automatic push(input logic [25:0] d);
      int n;
      n = 0;
      in_valid = 1'b1;
      in_data  = d;
      forever begin
         @(negedge clk);
         if (in_ready) begin
            @(posedge clk);
            #1;
            break;
         end
         n++;
         if (n > 200) begin
            chk("push_timeout", 32'd1, 32'd0);
            @(posedge clk);
            #1;
            break;
         end
      end
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst      = 1'b1;
      in_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (q.size() == 0) break;
      end
      chk("drain_empty", q.size(), 32'd0);
   endtask

   task automatic single(input logic [25:0] d, input logic [31:0] exp);
      out_ready = 1'b1;
      push(d);
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      chk("single_valid", {31'd0, out_valid}, 32'd1);
      chk("single_cw", out_codeword, exp);
   endtask

   initial begin
      // Pin the reference model to hand-computed codewords
      chk("model_0", model_enc(26'h0000000), 32'h00000000);
      chk("model_1", model_enc(26'h0000001), 32'hF8000001);
      chk("model_msb", model_enc(26'h2000000), 32'hC6000000);
      chk("model_ones", model_enc(26'h3FFFFFF), 32'hFFFFFFFF);

      // Reset, then idle
      rst = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_enc_count", {16'd0, enc_count}, 32'd0);
      chk("rst_codeword", out_codeword, 32'd0);

      // Single words, two cycles from accept to output
      single(26'h0000000, 32'h00000000);
      single(26'h0000001, 32'hF8000001);
      single(26'h2000000, 32'hC6000000);
      single(26'h3FFFFFF, 32'hFFFFFFFF);
      drain();

      // Continuous streaming from a fresh count
      do_reset();
      out_ready = 1'b1;
      for (int i = 0; i < 1000; i++) begin
         push(26'($urandom));
      end
      in_valid = 1'b0;
      drain();
      @(negedge clk);
      chk("stream_count", {16'd0, enc_count}, 32'd1000);

      // Backpressure: A and B fill the pipe, C is held at the source
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      push(26'h0000001);
      push(26'h2000000);
      in_valid = 1'b1;
      in_data  = 26'h3FFFFFF;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
         chk("bp_hold_cw", out_codeword, 32'hF8000001);
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      push(26'h3FFFFFF);
      in_valid = 1'b0;
      drain();
      @(negedge clk);
      chk("bp_count", {16'd0, enc_count}, 32'd1003);

      // Reset with two words in flight
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      push(26'h0ABCDEF);
      push(26'h1234567);
      in_valid = 1'b0;
      rst      = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
      chk("mid_rst_count", {16'd0, enc_count}, 32'd0);
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("mid_rst_no_stale", {31'd0, out_valid}, 32'd0);
      end

`ifdef HAM32_ERR_INJECT_EN
      // Single-bit and double-bit injection on the word for data 1
      err_inj_mask = 32'h00000001;
      single(26'h0000001, 32'hF8000000);
      chk("inj1_syn0", {31'd0, syndrome(out_codeword)[0]}, 32'd1);
      drain();
      err_inj_mask = 32'h00000003;
      single(26'h0000001, 32'hF8000002);
      chk("inj2_syn0", {31'd0, syndrome(out_codeword)[0]}, 32'd0);
      chk("inj2_syn_nz", {31'd0, (syndrome(out_codeword)[5:1] != 5'd0)}, 32'd1);
      drain();
      err_inj_mask = 32'h00000000;
`endif

      @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
